// File: rtl/mux_sel_arb.sv
// mux_sel_arb: round-robin A/B arbiter driving registered select sl, with break-before-make gap and 1-deep output register.
// Define SEL_LOCK_EN to add a lock input that holds the current select.
module mux_sel_arb #(
   parameter int DW        = 8,
   parameter int MAX_BURST = 4,
   parameter int GAP_CYC   = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_a,
   input  logic [DW-1:0] data_a,
   output logic          grant_a,
   input  logic          req_b,
   input  logic [DW-1:0] data_b,
   output logic          grant_b,
   output logic          sl,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready
`ifdef SEL_LOCK_EN
   ,
   input  logic          lock
`endif
);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN  = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;
   logic [1:0]    state;
   logic          last_owner;
   logic [BW-1:0] burst_cnt, cnt_nx;
   logic [GW-1:0] gap_cnt;
   logic          lk, req_own, req_oth, grant, win, burst_hit;
`ifdef SEL_LOCK_EN
   assign lk = lock;
`else
   assign lk = 1'b0;
`endif
   always_comb begin
      req_own   = sl ? req_b : req_a;
      req_oth   = sl ? req_a : req_b;
      grant     = (state == OWN) & req_own & (~out_valid | out_ready);
      grant_a   = grant & ~sl;
      grant_b   = grant & sl;
      cnt_nx    = burst_cnt + BW'(grant);
      burst_hit = cnt_nx == BW'(MAX_BURST);
      // on contention the side that did not own last wins
      win       = (req_a & req_b) ? ~last_owner : req_b;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         sl         <= 1'b0;
         last_owner <= 1'b1;
         out_valid  <= 1'b0;
         out_data   <= '0;
         burst_cnt  <= '0;
         gap_cnt    <= '0;
      end else begin
         out_valid <= grant | (out_valid & ~out_ready);
         if (grant) out_data <= sl ? data_b : data_a;
         case (state)
            IDLE:
               if (lk ? req_own : (req_a | req_b)) begin
                  if (lk || win == sl) state <= OWN;
                  else begin
                     state   <= GAP;
                     sl      <= ~sl;
                     gap_cnt <= '0;
                  end
               end
            OWN:
               if (!req_own) begin
                  last_owner <= sl;
                  burst_cnt  <= '0;
                  if (req_oth && !lk) begin
                     state   <= GAP;
                     sl      <= ~sl;
                     gap_cnt <= '0;
                  end else state <= IDLE;
               end else if (burst_hit) begin
                  burst_cnt <= '0;
                  if (req_oth && !lk) begin
                     state      <= GAP;
                     sl         <= ~sl;
                     gap_cnt    <= '0;
                     last_owner <= sl;
                  end
               end else burst_cnt <= cnt_nx;
            GAP:
               if (gap_cnt == GW'(GAP_CYC - 1)) begin
                  state     <= req_own ? OWN : IDLE;
                  burst_cnt <= '0;
               end else gap_cnt <= gap_cnt + GW'(1);
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_mux_sel_arb.sv
// tb_mux_sel_arb: directed cycle vectors with a word scoreboard drained by an output monitor.
// Lock scenario runs only when SEL_LOCK_EN is defined.
module tb_mux_sel_arb;
   localparam int DW = 8;
   logic clk = 1'b0, rst_n = 1'b1, req_a = 1'b0, req_b = 1'b0, out_ready = 1'b1;
   logic [DW-1:0] data_a, data_b, out_data;
   logic grant_a, grant_b, sl, out_valid;
`ifdef SEL_LOCK_EN
   logic lock = 1'b0;
`endif
   int tests = 0, fails = 0;
   int na = 0, nb = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] w;

   always #5 clk = ~clk;
   assign data_a = DW'(32'hA0 + na);
   assign data_b = DW'(32'hB0 + nb);

   mux_sel_arb #(.DW(DW), .MAX_BURST(4), .GAP_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .data_a(data_a), .grant_a(grant_a),
      .req_b(req_b), .data_b(data_b), .grant_b(grant_b),
      .sl(sl), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef SEL_LOCK_EN
      , .lock(lock)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one cycle: drive inputs, check grants/sl mid-cycle, record expected words
   task automatic vec(input logic ra, rb, rdy, ega, egb, esl);
      req_a = ra; req_b = rb; out_ready = rdy;
      @(negedge clk);
      chk("grant_a", grant_a, ega);
      chk("grant_b", grant_b, egb);
      chk("sl", sl, esl);
      if (ega) exp_q.push_back(data_a);
      if (egb) exp_q.push_back(data_b);
      @(posedge clk); #1;
      if (ega) na++;
      if (egb) nb++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1; na = 0; nb = 0;
      @(posedge clk); #1;
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   always @(negedge clk)
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL out_word: got %0h expected none at %0t", out_data, $time);
         end else begin
            w = exp_q.pop_front();
            chk("out_word", out_data, w);
         end
      end

   initial begin
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_sl", sl, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_grant_a", grant_a, 0);
      chk("rst_grant_b", grant_b, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) vec(0, 0, 1, 0, 0, 0);
      chk("idle_valid", out_valid, 0);
      // single A, three words
      vec(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) vec(1, 0, 1, 1, 0, 0);
      vec(0, 0, 1, 0, 0, 0);
      vec(0, 0, 1, 0, 0, 0);
      chk("single_done_valid", out_valid, 0);
      // both requesting from reset: 4 A, gap, 4 B, gap, 4 A
      do_reset();
      vec(1, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) vec(1, 1, 1, 1, 0, 0);
      vec(1, 1, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) vec(1, 1, 1, 0, 1, 1);
      vec(1, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) vec(1, 1, 1, 1, 0, 0);
      vec(0, 0, 1, 0, 0, 1);
      vec(0, 0, 1, 0, 0, 1);
      // backpressure holds word and blocks grants
      do_reset();
      vec(1, 0, 1, 0, 0, 0);
      vec(1, 0, 1, 1, 0, 0);
      vec(1, 0, 0, 0, 0, 0);
      vec(1, 0, 0, 0, 0, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 8'hA0);
      vec(1, 0, 1, 1, 0, 0);
      vec(0, 0, 1, 0, 0, 0);
      vec(0, 0, 1, 0, 0, 0);
      // async reset mid-burst on B
      do_reset();
      vec(0, 1, 1, 0, 0, 0);
      vec(0, 1, 1, 0, 0, 1);
      vec(0, 1, 1, 0, 1, 1);
      vec(0, 1, 1, 0, 1, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mr_sl", sl, 0);
      chk("mr_valid", out_valid, 0);
      chk("mr_grant_b", grant_b, 0);
      exp_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      vec(1, 1, 1, 0, 0, 0);
      vec(1, 1, 1, 1, 0, 0);
      vec(0, 0, 1, 0, 0, 0);
      vec(0, 0, 1, 0, 0, 0);
`ifdef SEL_LOCK_EN
      do_reset();
      lock = 1'b1;
      vec(1, 1, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) vec(1, 1, 1, 1, 0, 0);
      lock = 1'b0;
      vec(1, 1, 1, 1, 0, 0);
      vec(1, 1, 1, 1, 0, 0);
      vec(1, 1, 1, 0, 0, 1);
      vec(0, 0, 1, 0, 0, 1);
      vec(0, 0, 1, 0, 0, 1);
`endif
      vec(0, 0, 1, 0, 0, sl);
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
